// File: rtl/evaluador_estado_pkg.sv
// Shared definitions for the pet-state evaluator and the display driver:
// state codes, need indices and level constants.
package evaluador_estado_pkg;

  typedef enum logic [2:0] {
    FELIZ   = 3'd0,
    TRISTE  = 3'd1,
    CRITICO = 3'd2,
    ACCION  = 3'd3,
    MUERTO  = 3'd4
  } estado_t;

  localparam logic [1:0] NEC_HAMBRE    = 2'd0;
  localparam logic [1:0] NEC_SUENO     = 2'd1;
  localparam logic [1:0] NEC_DIVERSION = 2'd2;
  localparam logic [1:0] NEC_NINGUNA   = 2'd3;

  localparam logic [1:0] NIVEL_VACIO = 2'd0;
  localparam logic [1:0] NIVEL_BAJO  = 2'd1;
  localparam logic [1:0] NIVEL_LLENO = 2'd3;

endpackage

// File: rtl/evaluador_estado_minimo_nivel.sv
// Combinational minimum/argmin over the three need levels; ties go to the
// lowest index and a full minimum reports "no need".
module minimo_nivel
  import evaluador_estado_pkg::*;
(
  input  logic [1:0] nivel_hambre,
  input  logic [1:0] nivel_sueno,
  input  logic [1:0] nivel_diversion,
  output logic [1:0] minimo,
  output logic [1:0] indice
);

  logic [1:0] min_hs_s;
  logic [1:0] idx_hs_s;
  logic [1:0] idx_min_s;

  // Pairwise reduction; strict less-than keeps the lower index on ties
  always_comb begin
    min_hs_s  = nivel_hambre;
    idx_hs_s  = NEC_HAMBRE;
    minimo    = nivel_hambre;
    idx_min_s = NEC_HAMBRE;
    if (nivel_sueno < nivel_hambre) begin
      min_hs_s = nivel_sueno;
      idx_hs_s = NEC_SUENO;
    end else begin
      min_hs_s = nivel_hambre;
      idx_hs_s = NEC_HAMBRE;
    end
    if (nivel_diversion < min_hs_s) begin
      minimo    = nivel_diversion;
      idx_min_s = NEC_DIVERSION;
    end else begin
      minimo    = min_hs_s;
      idx_min_s = idx_hs_s;
    end
  end

  assign indice = (minimo == NIVEL_LLENO) ? NEC_NINGUNA : idx_min_s;

endmodule

// File: rtl/evaluador_estado.sv
// Pet-state evaluator: derives mood, lowest need, warning blink and death
// from the three need levels, with all outputs registered.
module evaluador_estado
  import evaluador_estado_pkg::*;
#(
  parameter int TIEMPO_MUERTE   = 15,
  parameter int TIEMPO_PARPADEO = 3
) (
  input  logic       clk,
  input  logic       B_reset,
  input  logic [1:0] Nivel_Hambre,
  input  logic [1:0] Nivel_Sueno,
  input  logic [1:0] Nivel_Diversion,
  input  logic       senal_5seg,
  output logic [2:0] Estado,
  output logic [1:0] Necesidad,
  output logic       Alerta,
  output logic       Muerto
);

  localparam int CW = $clog2(TIEMPO_MUERTE + 1);
  localparam int BW = (TIEMPO_PARPADEO > 1) ? $clog2(TIEMPO_PARPADEO) : 1;

  estado_t       estado_r, estado_s;
  logic [1:0]    necesidad_r, necesidad_s;
  logic          alerta_r, alerta_s;
  logic          muerto_r, muerto_s;
  logic [CW-1:0] cnt_muerte_r, cnt_muerte_s;
  logic [BW-1:0] cnt_parpadeo_r, cnt_parpadeo_s;
  logic [1:0]    minimo_s;
  logic [1:0]    indice_s;

  minimo_nivel u_minimo (
    .nivel_hambre    (Nivel_Hambre),
    .nivel_sueno     (Nivel_Sueno),
    .nivel_diversion (Nivel_Diversion),
    .minimo          (minimo_s),
    .indice          (indice_s)
  );

  // Next-state, death counter and lowest-need selection
  always_comb begin
    estado_s     = estado_r;
    necesidad_s  = necesidad_r;
    cnt_muerte_s = cnt_muerte_r;
    if (estado_r == MUERTO) begin
      estado_s     = MUERTO;
      necesidad_s  = necesidad_r;
      cnt_muerte_s = cnt_muerte_r;
    end else begin
      necesidad_s = indice_s;
      if (minimo_s == NIVEL_VACIO) begin
        if (cnt_muerte_r >= CW'(TIEMPO_MUERTE - 1)) begin
          cnt_muerte_s = CW'(TIEMPO_MUERTE);
          estado_s     = MUERTO;
        end else begin
          cnt_muerte_s = cnt_muerte_r + CW'(1);
          estado_s     = senal_5seg ? ACCION : CRITICO;
        end
      end else begin
        cnt_muerte_s = '0;
        if (senal_5seg) begin
          estado_s = ACCION;
        end else if (minimo_s == NIVEL_BAJO) begin
          estado_s = TRISTE;
        end else begin
          estado_s = FELIZ;
        end
      end
    end
  end

  // Warning output and blink timing, keyed on the upcoming state
  always_comb begin
    alerta_s       = 1'b0;
    cnt_parpadeo_s = '0;
    muerto_s       = (estado_s == MUERTO);
    case (estado_s)
      FELIZ, ACCION: begin
        alerta_s       = 1'b0;
        cnt_parpadeo_s = '0;
      end
      TRISTE, MUERTO: begin
        alerta_s       = 1'b1;
        cnt_parpadeo_s = '0;
      end
      CRITICO: begin
        if (estado_r != CRITICO) begin
          alerta_s       = 1'b1;
          cnt_parpadeo_s = '0;
        end else if (cnt_parpadeo_r >= BW'(TIEMPO_PARPADEO - 1)) begin
          alerta_s       = ~alerta_r;
          cnt_parpadeo_s = '0;
        end else begin
          alerta_s       = alerta_r;
          cnt_parpadeo_s = cnt_parpadeo_r + BW'(1);
        end
      end
      default: begin
        alerta_s       = 1'b0;
        cnt_parpadeo_s = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (B_reset) begin
      estado_r       <= FELIZ;
      necesidad_r    <= NEC_NINGUNA;
      alerta_r       <= 1'b0;
      muerto_r       <= 1'b0;
      cnt_muerte_r   <= '0;
      cnt_parpadeo_r <= '0;
    end else begin
      estado_r       <= estado_s;
      necesidad_r    <= necesidad_s;
      alerta_r       <= alerta_s;
      muerto_r       <= muerto_s;
      cnt_muerte_r   <= cnt_muerte_s;
      cnt_parpadeo_r <= cnt_parpadeo_s;
    end
  end

  assign Estado    = estado_r;
  assign Necesidad = necesidad_r;
  assign Alerta    = alerta_r;
  assign Muerto    = muerto_r;

endmodule

// File: tb/tb_evaluador_estado.sv
// Scoreboard bench for evaluador_estado: each stimulus cycle queues its
// hand-computed expected outputs, a monitor pops and compares after the edge.
module tb_evaluador_estado;

  localparam int E_FELIZ = 0, E_TRISTE = 1, E_CRITICO = 2, E_ACCION = 3, E_MUERTO = 4;

  typedef struct {
    int    e;
    int    n;
    int    a;
    int    m;
    string tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       B_reset = 1'b1;
  logic [1:0] Nivel_Hambre = 2'd3;
  logic [1:0] Nivel_Sueno = 2'd3;
  logic [1:0] Nivel_Diversion = 2'd3;
  logic       senal_5seg = 1'b0;
  logic [2:0] Estado;
  logic [1:0] Necesidad;
  logic       Alerta;
  logic       Muerto;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  bit   done = 1'b0;

  evaluador_estado #(.TIEMPO_MUERTE(15), .TIEMPO_PARPADEO(3)) dut (
    .clk             (clk),
    .B_reset         (B_reset),
    .Nivel_Hambre    (Nivel_Hambre),
    .Nivel_Sueno     (Nivel_Sueno),
    .Nivel_Diversion (Nivel_Diversion),
    .senal_5seg      (senal_5seg),
    .Estado          (Estado),
    .Necesidad       (Necesidad),
    .Alerta          (Alerta),
    .Muerto          (Muerto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end else begin
      passed++;
    end
  endtask

  task automatic step(input int h, input int s, input int d, input int sn, input int rst,
                      input int e, input int n, input int a, input int m, input string tag);
    exp_t x;
    @(negedge clk);
    Nivel_Hambre    = h[1:0];
    Nivel_Sueno     = s[1:0];
    Nivel_Diversion = d[1:0];
    senal_5seg      = sn[0];
    B_reset         = rst[0];
    x.e = e; x.n = n; x.a = a; x.m = m; x.tag = tag;
    q.push_back(x);
  endtask

  function automatic int blink(input int k);
    return (((k - 1) / 3) % 2 == 0) ? 1 : 0;
  endfunction

  // Monitor: one expected entry per cycle, compared just after the edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk({x.tag, ".estado"}, int'(Estado), x.e);
        chk({x.tag, ".necesidad"}, int'(Necesidad), x.n);
        chk({x.tag, ".alerta"}, int'(Alerta), x.a);
        chk({x.tag, ".muerto"}, int'(Muerto), x.m);
      end
    end
  end

  initial begin
    // Reset and basic mood/need mapping
    step(3, 3, 3, 0, 1, E_FELIZ, 3, 0, 0, "reset0");
    step(3, 3, 3, 0, 1, E_FELIZ, 3, 0, 0, "reset1");
    step(3, 3, 3, 0, 0, E_FELIZ, 3, 0, 0, "full");
    step(3, 1, 1, 0, 0, E_TRISTE, 1, 1, 0, "triste_tie");
    step(2, 3, 2, 0, 0, E_FELIZ, 0, 0, 0, "feliz_tie02");
    step(3, 3, 2, 0, 0, E_FELIZ, 2, 0, 0, "feliz_div");
    step(2, 2, 1, 0, 0, E_TRISTE, 2, 1, 0, "triste_div");

    // Hunger empty until death, then inputs ignored
    for (int k = 1; k <= 14; k++) step(0, 3, 3, 0, 0, E_CRITICO, 0, blink(k), 0, "critico");
    step(0, 3, 3, 0, 0, E_MUERTO, 0, 1, 1, "muere15");
    for (int k = 0; k < 3; k++) step(3, 3, 3, 1, 0, E_MUERTO, 0, 1, 1, "muerto_hold");

    // Reset out of death
    step(3, 3, 3, 0, 1, E_FELIZ, 3, 0, 0, "reset_muerto");
    step(3, 3, 3, 0, 0, E_FELIZ, 3, 0, 0, "post_reset");

    // Counter restarts after a one-cycle recovery
    for (int k = 1; k <= 10; k++) step(0, 3, 3, 0, 0, E_CRITICO, 0, blink(k), 0, "pre_gap");
    step(2, 3, 3, 0, 0, E_FELIZ, 0, 0, 0, "gap");
    for (int k = 1; k <= 14; k++) step(0, 3, 3, 0, 0, E_CRITICO, 0, blink(k), 0, "post_gap");
    step(0, 3, 3, 0, 0, E_MUERTO, 0, 1, 1, "muere_gap");
    step(3, 3, 3, 0, 1, E_FELIZ, 3, 0, 0, "reset2");

    // Action window, then action while starving keeps the counter running
    for (int k = 0; k < 7; k++) step(2, 2, 2, 1, 0, E_ACCION, 0, 0, 0, "accion");
    step(2, 2, 2, 0, 0, E_FELIZ, 0, 0, 0, "fin_accion");
    for (int k = 1; k <= 7; k++) step(0, 2, 2, 1, 0, E_ACCION, 0, 0, 0, "accion_vacio");
    for (int k = 1; k <= 7; k++) step(0, 2, 2, 0, 0, E_CRITICO, 0, blink(k), 0, "tras_accion");
    step(0, 2, 2, 0, 0, E_MUERTO, 0, 1, 1, "muere_accion");

    // Reset mid-count overrides everything
    step(3, 3, 3, 0, 1, E_FELIZ, 3, 0, 0, "reset3");
    for (int k = 1; k <= 5; k++) step(0, 3, 3, 0, 0, E_CRITICO, 0, blink(k), 0, "mid");
    step(0, 3, 3, 1, 1, E_FELIZ, 3, 0, 0, "reset_mid");
    step(3, 3, 3, 0, 0, E_FELIZ, 3, 0, 0, "final");

    for (int k = 0; k < 3; k++) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    done = 1'b1;
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/evaluador_estado.md
EVALUADOR_ESTADO -- requirements
Module: evaluador_estado

Interface
REQ-001 Parameter TIEMPO_MUERTE, default 15: consecutive clk cycles with any need at level 0 before death.
REQ-002 Parameter TIEMPO_PARPADEO, default 3: clk cycles per Alerta toggle in CRITICO.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 B_reset  input  1  synchronous, active-high reset.
REQ-005 Nivel_Hambre  input  [0:1]  hunger need level, 0 = empty, 3 = full.
REQ-006 Nivel_Sueno  input  [0:1]  sleep need level, same encoding.
REQ-007 Nivel_Diversion  input  [0:1]  fun need level, same encoding.
REQ-008 senal_5seg  input  1  high while any need module's post-action window is active (OR-ed upstream).
REQ-009 Estado  output  [0:2]  pet state code: FELIZ=0, TRISTE=1, CRITICO=2, ACCION=3, MUERTO=4.
REQ-010 Necesidad  output  [0:1]  index of lowest need: 0 hambre, 1 sueno, 2 diversion, 3 none.
REQ-011 Alerta  output  1  warning indicator for display/LED.
REQ-012 Muerto  output  1  high exactly when Estado = MUERTO.

Function
REQ-013 The block SHALL compute min = minimum of the three levels each cycle from current inputs.
REQ-014 All outputs SHALL be registered; an input change SHALL be reflected one clk cycle later.
REQ-015 Next state SHALL follow this priority: MUERTO holds; death counter reaching TIEMPO_MUERTE -> MUERTO; senal_5seg = 1 -> ACCION; min = 0 -> CRITICO; min = 1 -> TRISTE; min >= 2 -> FELIZ.
REQ-016 MUERTO SHALL be absorbing; only B_reset leaves it; level and senal_5seg inputs are ignored there.
REQ-017 The death counter SHALL increment on every non-MUERTO cycle with min = 0 (including while in ACCION) and clear to 0 on any cycle with min > 0.
REQ-018 Death SHALL occur on the edge where the counter would reach TIEMPO_MUERTE, i.e. after exactly TIEMPO_MUERTE consecutive min = 0 cycles; the counter saturates and does not wrap.
REQ-019 Necesidad SHALL give the index of the need equal to min, ties resolved to the lowest index; it SHALL be 3 when min = 3.
REQ-020 Necesidad SHALL freeze at its last value while in MUERTO.
REQ-021 Alerta SHALL be 0 in FELIZ and ACCION, constant 1 in TRISTE and MUERTO, and toggle every TIEMPO_PARPADEO cycles in CRITICO.
REQ-022 On entry to CRITICO, Alerta SHALL be 1 and the blink counter SHALL restart from 0; the blink counter SHALL be held at 0 outside CRITICO.
REQ-023 ACCION SHALL end on the cycle after senal_5seg falls; the state then follows REQ-015 from current levels.

Reset
REQ-024 With B_reset = 1 at an edge: Estado = FELIZ, Necesidad = 3, Alerta = 0, Muerto = 0, death and blink counters = 0.
REQ-025 B_reset SHALL override all other inputs, including in MUERTO and mid-count.

Structure
REQ-026 State codes and need-index constants SHALL live in a shared include file used by this block and the display driver.
REQ-027 Min/argmin selection SHALL be a combinational sub-module named minimo_nivel, with three levels in and min plus index out.

Verification (TIEMPO_MUERTE = 15, TIEMPO_PARPADEO = 3)
REQ-028 Reset, levels 3/3/3 -> Estado 0, Necesidad 3, Alerta 0, Muerto 0.
REQ-029 Levels 3/1/1 -> one cycle later Estado 1, Necesidad 1, Alerta 1.
REQ-030 Hambre = 0 held -> Estado 2, Alerta pattern 1,1,1,0,0,0,...; Estado 4 and Muerto 1 after 15 zero cycles; raising Hambre to 3 afterwards -> stays 4.
REQ-031 Hambre = 0 for 10 cycles, then 2 for 1 cycle, then 0 again -> counter restarts; no death before 15 further cycles.
REQ-032 Levels 2/2/2 with senal_5seg high for 7 cycles -> Estado 3 for 7 cycles, then 0; with Hambre = 0 during ACCION, the death counter keeps counting.
REQ-033 B_reset pulsed while in MUERTO, levels 3/3/3 -> next cycle Estado 0, Muerto 0, Alerta 0.
